// File: rtl/issue_hazard.sv
// Issue stage ahead of the 16x8 register file: scoreboard-based RAW/WAW stall,
// register-file address mux, and issue output aligned with the 1-cycle RF read.
// Optional hazard stall counter enabled by the ISSUE_STALL_CNT_EN macro.
module issue_hazard #(
    parameter int unsigned BIT = 8,
    parameter int unsigned SZB = 4,
    parameter int unsigned OPW = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [OPW+3*SZB-1:0]   in_instr,
    output logic [SZB-1:0]         addr_rs0,
    output logic [SZB-1:0]         addr_rs1,
    input  logic [BIT-1:0]         rf_rs0,
    input  logic [BIT-1:0]         rf_rs1,
    input  logic                   wb_valid,
    input  logic [SZB-1:0]         wb_addr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OPW-1:0]         out_op,
    output logic [SZB-1:0]         out_rd,
    output logic [BIT-1:0]         out_rs0,
    output logic [BIT-1:0]         out_rs1
`ifdef ISSUE_STALL_CNT_EN
    ,
    output logic [15:0]            stall_count
`endif
);

    localparam int unsigned IW  = OPW + 3 * SZB;
    localparam int unsigned SZA = 2 ** SZB;

    logic [IW-1:0]  ir;
    logic [SZA-1:0] pend;
    logic [SZA-1:0] pend_next;

    logic [OPW-1:0] in_op;
    logic [SZB-1:0] in_rd;
    logic [SZB-1:0] in_rs0;
    logic [SZB-1:0] in_rs1;
    logic           writes_rd;
    logic           hazard;
    logic           accept;

    assign in_op  = in_instr[IW-1 -: OPW];
    assign in_rd  = in_instr[3*SZB-1 -: SZB];
    assign in_rs0 = in_instr[2*SZB-1 -: SZB];
    assign in_rs1 = in_instr[SZB-1:0];

    // NOP (all zeros) and STORE (all ones) have no destination
    assign writes_rd = (in_op != '0) && (in_op != '1);

    assign hazard   = pend[in_rs0] | pend[in_rs1] | (writes_rd & pend[in_rd]);
    assign in_ready = !hazard && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Holding the ir addresses keeps RF data stable while the output is stalled
    assign addr_rs0 = accept ? in_rs0 : ir[2*SZB-1 -: SZB];
    assign addr_rs1 = accept ? in_rs1 : ir[SZB-1:0];

    assign out_rs0 = rf_rs0;
    assign out_rs1 = rf_rs1;

    // Clear applied before set so a same-cycle set of the same index wins
    always_comb begin
        pend_next = pend;
        if (wb_valid)
            pend_next[wb_addr] = 1'b0;
        if (accept && writes_rd)
            pend_next[in_rd] = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pend <= '0;
        end else begin
            pend <= pend_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ir        <= '0;
            out_valid <= 1'b0;
            out_op    <= '0;
            out_rd    <= '0;
        end else if (accept) begin
            ir        <= in_instr;
            out_valid <= 1'b1;
            out_op    <= in_op;
            out_rd    <= in_rd;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef ISSUE_STALL_CNT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
        end else if (in_valid && hazard && (stall_count != '1)) begin
            stall_count <= stall_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_issue_hazard.sv
// Directed self-checking bench for issue_hazard with a registered-read RF model
// whose register i reads back as 8'hA0 + i.
module tb_issue_hazard;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic [3:0]  addr_rs0;
    logic [3:0]  addr_rs1;
    logic [7:0]  rf_rs0;
    logic [7:0]  rf_rs1;
    logic        wb_valid;
    logic [3:0]  wb_addr;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_op;
    logic [3:0]  out_rd;
    logic [7:0]  out_rs0;
    logic [7:0]  out_rs1;
`ifdef ISSUE_STALL_CNT_EN
    logic [15:0] stall_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    issue_hazard #(.BIT(8), .SZB(4), .OPW(4)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .addr_rs0(addr_rs0), .addr_rs1(addr_rs1),
        .rf_rs0(rf_rs0), .rf_rs1(rf_rs1),
        .wb_valid(wb_valid), .wb_addr(wb_addr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_rd(out_rd),
        .out_rs0(out_rs0), .out_rs1(out_rs1)
`ifdef ISSUE_STALL_CNT_EN
        , .stall_count(stall_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always_ff @(posedge clock) begin
        rf_rs0 <= 8'hA0 + {4'h0, addr_rs0};
        rf_rs1 <= 8'hA0 + {4'h0, addr_rs1};
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_instr = '0; wb_valid = 1'b0; wb_addr = '0; out_ready = 1'b0;
        tick(); tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %0h exp 0", out_valid); end
        n_cmp++; if (out_op !== 4'h0) begin n_err++; $display("FAIL reset_out_op got %0h exp 0", out_op); end
        n_cmp++; if (out_rd !== 4'h0) begin n_err++; $display("FAIL reset_out_rd got %0h exp 0", out_rd); end
        n_cmp++; if (addr_rs0 !== 4'h0) begin n_err++; $display("FAIL reset_addr_rs0 got %0h exp 0", addr_rs0); end
        n_cmp++; if (addr_rs1 !== 4'h0) begin n_err++; $display("FAIL reset_addr_rs1 got %0h exp 0", addr_rs1); end
        n_cmp++; if (dut.pend !== 16'h0000) begin n_err++; $display("FAIL reset_pend got %0h exp 0", dut.pend); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        in_valid = 1'b1; in_instr = 16'h1123; out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL basic_in_ready got %0h exp 1", in_ready); end
        n_cmp++; if (addr_rs0 !== 4'h2) begin n_err++; $display("FAIL basic_addr_rs0 got %0h exp 2", addr_rs0); end
        n_cmp++; if (addr_rs1 !== 4'h3) begin n_err++; $display("FAIL basic_addr_rs1 got %0h exp 3", addr_rs1); end
        tick();
        in_valid = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_out_valid got %0h exp 1", out_valid); end
        n_cmp++; if (out_op !== 4'h1) begin n_err++; $display("FAIL basic_out_op got %0h exp 1", out_op); end
        n_cmp++; if (out_rd !== 4'h1) begin n_err++; $display("FAIL basic_out_rd got %0h exp 1", out_rd); end
        n_cmp++; if (out_rs0 !== 8'hA2) begin n_err++; $display("FAIL basic_out_rs0 got %0h exp a2", out_rs0); end
        n_cmp++; if (out_rs1 !== 8'hA3) begin n_err++; $display("FAIL basic_out_rs1 got %0h exp a3", out_rs1); end
        n_cmp++; if (dut.pend !== 16'h0002) begin n_err++; $display("FAIL basic_pend got %0h exp 0002", dut.pend); end
        wb_valid = 1'b1; wb_addr = 4'h1;
        tick();
        wb_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_drain got %0h exp 0", out_valid); end
        n_cmp++; if (dut.pend !== 16'h0000) begin n_err++; $display("FAIL basic_wb_clear got %0h exp 0", dut.pend); end
    endtask

    task automatic test_raw();
        in_valid = 1'b1; in_instr = 16'h1523; out_ready = 1'b1;
        tick();
        in_instr = 16'h2651;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL raw_stall0 got %0h exp 0", in_ready); end
        n_cmp++; if (addr_rs0 !== 4'h2) begin n_err++; $display("FAIL raw_hold_addr_rs0 got %0h exp 2", addr_rs0); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL raw_stall%0d got %0h exp 0", i + 1, in_ready); end
        end
        wb_valid = 1'b1; wb_addr = 4'h5;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL raw_clear_cycle got %0h exp 0", in_ready); end
        tick();
        wb_valid = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL raw_after_clear got %0h exp 1", in_ready); end
        n_cmp++; if (addr_rs0 !== 4'h5) begin n_err++; $display("FAIL raw_addr_rs0 got %0h exp 5", addr_rs0); end
        n_cmp++; if (addr_rs1 !== 4'h1) begin n_err++; $display("FAIL raw_addr_rs1 got %0h exp 1", addr_rs1); end
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL raw_out_valid got %0h exp 1", out_valid); end
        n_cmp++; if (out_op !== 4'h2) begin n_err++; $display("FAIL raw_out_op got %0h exp 2", out_op); end
        n_cmp++; if (out_rd !== 4'h6) begin n_err++; $display("FAIL raw_out_rd got %0h exp 6", out_rd); end
        n_cmp++; if (out_rs0 !== 8'hA5) begin n_err++; $display("FAIL raw_out_rs0 got %0h exp a5", out_rs0); end
        n_cmp++; if (out_rs1 !== 8'hA1) begin n_err++; $display("FAIL raw_out_rs1 got %0h exp a1", out_rs1); end
        n_cmp++; if (dut.pend !== 16'h0040) begin n_err++; $display("FAIL raw_pend got %0h exp 0040", dut.pend); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 16'h3701;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready%0d got %0h exp 0", i, in_ready); end
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_out_valid%0d got %0h exp 1", i, out_valid); end
            n_cmp++; if ({out_op, out_rd} !== 8'h26) begin n_err++; $display("FAIL bp_op_rd%0d got %0h exp 26", i, {out_op, out_rd}); end
            n_cmp++; if ({out_rs0, out_rs1} !== 16'hA5A1) begin n_err++; $display("FAIL bp_data%0d got %0h exp a5a1", i, {out_rs0, out_rs1}); end
            n_cmp++; if ({addr_rs0, addr_rs1} !== 8'h51) begin n_err++; $display("FAIL bp_addr%0d got %0h exp 51", i, {addr_rs0, addr_rs1}); end
            tick();
        end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release got %0h exp 1", in_ready); end
        n_cmp++; if ({addr_rs0, addr_rs1} !== 8'h01) begin n_err++; $display("FAIL bp_new_addr got %0h exp 01", {addr_rs0, addr_rs1}); end
        tick();
        in_valid = 1'b0;
        n_cmp++; if ({out_valid, out_op, out_rd} !== 9'h137) begin n_err++; $display("FAIL bp_next_out got %0h exp 137", {out_valid, out_op, out_rd}); end
        n_cmp++; if ({out_rs0, out_rs1} !== 16'hA0A1) begin n_err++; $display("FAIL bp_next_data got %0h exp a0a1", {out_rs0, out_rs1}); end
        n_cmp++; if (dut.pend !== 16'h00C0) begin n_err++; $display("FAIL bp_pend got %0h exp 00c0", dut.pend); end
        wb_valid = 1'b1; wb_addr = 4'h6;
        tick();
        wb_addr = 4'h7;
        tick();
        wb_valid = 1'b0;
        n_cmp++; if ({out_valid, dut.pend} !== 17'h0) begin n_err++; $display("FAIL bp_drain got %0h exp 0", {out_valid, dut.pend}); end
    endtask

    task automatic test_nonwriters();
        in_valid = 1'b1; in_instr = 16'h0012; out_ready = 1'b1;
        tick();
        in_instr = 16'hF912;
        tick();
        in_valid = 1'b0;
        n_cmp++; if (dut.pend !== 16'h0000) begin n_err++; $display("FAIL nw_pend got %0h exp 0", dut.pend); end
        n_cmp++; if ({out_valid, out_op, out_rd} !== 9'h1F9) begin n_err++; $display("FAIL nw_store_out got %0h exp 1f9", {out_valid, out_op, out_rd}); end
        wb_valid = 1'b1; wb_addr = 4'h7;
        tick();
        wb_valid = 1'b0;
        n_cmp++; if (dut.pend !== 16'h0000) begin n_err++; $display("FAIL nw_wb_nonpend got %0h exp 0", dut.pend); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL nw_drain got %0h exp 0", out_valid); end
    endtask

    task automatic test_set_wins();
        in_valid = 1'b1; in_instr = 16'h3823; out_ready = 1'b1;
        wb_valid = 1'b1; wb_addr = 4'h8;
        tick();
        in_valid = 1'b0; wb_valid = 1'b0;
        n_cmp++; if (dut.pend !== 16'h0100) begin n_err++; $display("FAIL setwins_pend got %0h exp 0100", dut.pend); end
        wb_valid = 1'b1;
        tick();
        wb_valid = 1'b0;
        n_cmp++; if (dut.pend !== 16'h0000) begin n_err++; $display("FAIL setwins_clear got %0h exp 0", dut.pend); end
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; in_instr = 16'h1123; out_ready = 1'b1;
        tick();
        in_instr = 16'h1545;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        n_cmp++; if ({out_valid, dut.pend} !== 17'h10022) begin n_err++; $display("FAIL rmid_pre got %0h exp 10022", {out_valid, dut.pend}); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_out_valid got %0h exp 0", out_valid); end
        n_cmp++; if (dut.pend !== 16'h0000) begin n_err++; $display("FAIL rmid_pend got %0h exp 0", dut.pend); end
        tick();
        reset = 1'b0;
        in_valid = 1'b1; in_instr = 16'h1123; out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rmid_ready got %0h exp 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_cmp++; if ({out_valid, out_rd} !== 5'h11) begin n_err++; $display("FAIL rmid_accept got %0h exp 11", {out_valid, out_rd}); end
    endtask

`ifdef ISSUE_STALL_CNT_EN
    task automatic test_stall_cnt();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        in_valid = 1'b1; in_instr = 16'h1123; out_ready = 1'b1;
        tick();
        in_instr = 16'h2211;
        for (int i = 0; i < 10; i++) tick();
        n_cmp++; if (stall_count !== 16'd10) begin n_err++; $display("FAIL stall_cnt10 got %0d exp 10", stall_count); end
        for (int i = 0; i < 65530; i++) tick();
        n_cmp++; if (stall_count !== 16'hFFFF) begin n_err++; $display("FAIL stall_cnt_sat got %0h exp ffff", stall_count); end
        tick(); tick();
        n_cmp++; if (stall_count !== 16'hFFFF) begin n_err++; $display("FAIL stall_cnt_hold got %0h exp ffff", stall_count); end
        in_valid = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_raw();
        test_backpressure();
        test_nonwriters();
        test_set_wins();
        test_reset_mid();
`ifdef ISSUE_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
